// File: rtl/aes_input_packer.sv
// Ingress packer for the AES first round: builds 128-bit blocks from 32-bit words,
// queues data blocks in a small FIFO and sequences key loads behind queued data.

package aes_input_packer_pkg;

  // Packet handed to the first round: valid MSB, en_de LSB
  typedef struct packed {
    logic         valid;
    logic [127:0] data;
    logic         en_de;
  } out_packet_t;

endpackage

module aes_input_packer
  import aes_input_packer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      word_in,
  input  logic [1:0]       word_cmd,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             out_en,
  input  logic             flush,
  output out_packet_t      data_out,
  output logic [127:0]     key_out,
  output logic             set_key,
  output logic             set_inv_key,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRY_W = 129;

  logic [1:0]         word_cnt;
  logic [1:0]         cmd_reg;
  logic [95:0]        asm_reg;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic         pop;
  logic         push;
  logic         key_load;
  logic         accept;
  logic         last_word;
  logic         fifo_full;
  logic         key_busy;
  logic [127:0] block;

  // Handshake and block-completion decode
  always_comb begin
    pop        = 1'b0;
    push       = 1'b0;
    key_load   = 1'b0;
    accept     = 1'b0;
    last_word  = 1'b0;
    fifo_full  = 1'b0;
    key_busy   = 1'b0;
    word_ready = 1'b1;
    block      = {asm_reg, word_in};

    pop       = out_en && (fifo_count != '0);
    fifo_full = (fifo_count == CNT_W'(DEPTH));
    key_busy  = (fifo_count != '0) || data_out.valid || set_key || set_inv_key;
    last_word = (word_cnt == 2'd3);

    if (flush) begin
      word_ready = 1'b0;
    end else if (last_word && !cmd_reg[1] && fifo_full && !pop) begin
      word_ready = 1'b0;
    end else if (last_word && cmd_reg[1] && key_busy) begin
      word_ready = 1'b0;
    end

    accept   = word_valid && word_ready;
    push     = accept && last_word && !cmd_reg[1];
    key_load = accept && last_word && cmd_reg[1];
  end

  // Word counter, command capture and MSB-first assembly shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= 2'd0;
      cmd_reg  <= 2'b00;
      asm_reg  <= '0;
    end else if (flush) begin
      word_cnt <= 2'd0;
    end else if (accept) begin
      word_cnt <= word_cnt + 2'd1;
      asm_reg  <= {asm_reg[63:0], word_in};
      if (word_cnt == 2'd0) begin
        cmd_reg <= word_cmd;
      end
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {block, cmd_reg[0]};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Registered packet output: one popped block per cycle, zeroed otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (flush) begin
      data_out <= '0;
    end else if (pop) begin
      data_out <= out_packet_t'({1'b1, mem[rd_ptr]});
    end else begin
      data_out <= '0;
    end
  end

  // Key register and one-cycle load pulses; unaffected by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out     <= '0;
      set_key     <= 1'b0;
      set_inv_key <= 1'b0;
    end else begin
      set_key     <= key_load && !cmd_reg[0];
      set_inv_key <= key_load && cmd_reg[0];
      if (key_load) begin
        key_out <= block;
      end
    end
  end

endmodule
